// File: rtl/scs8hd_cell3_bist.sv
// BIST sequencer for 3-input scs8hd cells: walks {CN,B,A} through 0..7 and compares X against TRUTH.
// Optional SCS8HD_BIST_STOPFAIL_EN: end the run at the first mismatching vector.
module scs8hd_cell3_bist #(
  parameter logic [7:0] TRUTH  = 8'hEF,
  parameter int         SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       start,
  input  logic       obs_x,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_cn,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_idx,
  output logic [3:0] err_count
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] err_nxt;
  logic [2:0] fidx_nxt;
  logic       pass_nxt;
  logic       mism;
  logic       last;
  logic       run_nxt;

  assign mism = (obs_x != TRUTH[idx]);

`ifdef SCS8HD_BIST_STOPFAIL_EN
  assign last = (idx == 3'd7) || mism;
`else
  assign last = (idx == 3'd7);
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    err_nxt   = err_count;
    fidx_nxt  = fail_idx;
    pass_nxt  = pass;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_DRIVE;
          idx_nxt   = 3'd0;
          cnt_nxt   = 4'd0;
          err_nxt   = 4'd0;
          fidx_nxt  = 3'd0;
          pass_nxt  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt == SETTLE_M1) state_nxt = S_SAMPLE;
        else                  cnt_nxt   = cnt + 4'd1;
      end
      S_SAMPLE: begin
        if (mism) begin
          err_nxt = err_count + 4'd1;
          if (err_count == 4'd0) fidx_nxt = idx;
        end
        // pass must include this final compare, so it is taken from err_nxt
        if (last) begin
          state_nxt = S_DONE;
          pass_nxt  = (err_nxt == 4'd0);
        end else begin
          state_nxt = S_DRIVE;
          idx_nxt   = idx + 3'd1;
          cnt_nxt   = 4'd0;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign run_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_SAMPLE);

  // All outputs are registered off next-state so the cell sees glitch-free pins.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      cnt       <= 4'd0;
      err_count <= 4'd0;
      fail_idx  <= 3'd0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drv_a     <= 1'b0;
      drv_b     <= 1'b0;
      drv_cn    <= 1'b0;
    end else begin
      state                  <= state_nxt;
      idx                    <= idx_nxt;
      cnt                    <= cnt_nxt;
      err_count              <= err_nxt;
      fail_idx               <= fidx_nxt;
      pass                   <= pass_nxt;
      busy                   <= run_nxt;
      done                   <= (state_nxt == S_DONE);
      {drv_cn, drv_b, drv_a} <= run_nxt ? idx_nxt : 3'b000;
    end
  end

endmodule

// File: tb/tb_scs8hd_cell3_bist.sv
// Randomised bench for scs8hd_cell3_bist: a cell model drives obs_x and a vector-level model predicts results.
module tb_scs8hd_cell3_bist;
  localparam logic [7:0] TRUTH  = 8'hEF;
  localparam int         SETTLE = 2;

  logic       CLK = 1'b0;
  logic       RESETB = 1'b0;
  logic       start = 1'b0;
  logic       obs_x;
  logic       drv_a, drv_b, drv_cn, busy, done, pass;
  logic [2:0] fail_idx;
  logic [3:0] err_count;
  logic [7:0] cell_tt = TRUTH;

  int n_chk = 0;
  int n_fail = 0;

  scs8hd_cell3_bist #(.TRUTH(TRUTH), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RESETB(RESETB), .start(start), .obs_x(obs_x),
    .drv_a(drv_a), .drv_b(drv_b), .drv_cn(drv_cn),
    .busy(busy), .done(done), .pass(pass),
    .fail_idx(fail_idx), .err_count(err_count)
  );

  // Cell under test: arbitrary (possibly faulty) function of its pins
  assign obs_x = cell_tt[{drv_cn, drv_b, drv_a}];

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected run outcome from vector-level rules
  task automatic model(input logic [7:0] tt, output int e_err, output int e_fidx,
                       output int e_pass, output int e_len, output int e_nv);
    e_err = 0; e_fidx = 0; e_nv = 8;
    for (int i = 0; i < 8; i++) begin
      if (e_nv == 8 || i < e_nv) begin
        if (tt[i] != TRUTH[i]) begin
          if (e_err == 0) e_fidx = i;
          e_err++;
`ifdef SCS8HD_BIST_STOPFAIL_EN
          if (e_err == 1) e_nv = i + 1;
`endif
        end
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
    e_len  = e_nv * (SETTLE + 1) + 1;
  endtask

  task automatic run(input logic [7:0] tt, input bit spam);
    int e_err, e_fidx, e_pass, e_len, e_nv;
    model(tt, e_err, e_fidx, e_pass, e_len, e_nv);
    cell_tt = tt;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    for (int n = 1; n <= e_len; n++) begin
      @(negedge CLK);
      start = spam ? (($urandom_range(0, 1) == 1) || (n == e_len)) : 1'b0;
      if (n < e_len) begin
        chk("busy", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
        chk("drv", 32'({drv_cn, drv_b, drv_a}), (n - 1) / (SETTLE + 1));
        if (n == 1) chk("pass_clr", 32'(pass), 0);
      end else begin
        chk("done", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("drv_done", 32'({drv_cn, drv_b, drv_a}), 0);
        chk("pass", 32'(pass), e_pass);
        chk("fail_idx", 32'(fail_idx), e_fidx);
        chk("err_count", 32'(err_count), e_err);
      end
    end
    @(negedge CLK);
    start = 1'b0;
    chk("done_pulse", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("pass_hold", 32'(pass), e_pass);
    chk("err_hold", 32'(err_count), e_err);
    @(negedge CLK);
    chk("no_restart", 32'(busy), 0);
  endtask

  initial begin
    int dones;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_drv", 32'({drv_cn, drv_b, drv_a}), 0);
    chk("rst_fidx", 32'(fail_idx), 0);
    chk("rst_err", 32'(err_count), 0);
    @(negedge CLK);
    RESETB = 1'b1;

    run(TRUTH, 1'b0);   // correct OR3 with inverted C
    run(8'hFF, 1'b0);   // X stuck at 1
    run(8'h00, 1'b0);   // X stuck at 0
    run(TRUTH, 1'b1);   // start spammed while busy and in DONE

    // Reset during vector 3 aborts with no done pulse
    cell_tt = TRUTH;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    for (int n = 1; n <= 10; n++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    RESETB = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_drv", 32'({drv_cn, drv_b, drv_a}), 0);
    chk("abort_err", 32'(err_count), 0);
    @(negedge CLK);
    RESETB = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run(TRUTH, 1'b0);

    for (int r = 0; r < 8; r++)
      run(TRUTH ^ (8'($urandom) & 8'($urandom)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scs8hd_cell3_bist.md
Name: scs8hd_cell3_bist

Overview:
- Built-in self-test sequencer for 3-input combinational cells in the scs8hd library, for example OR3 with inverted C.
- Acts as the initiator side of the cell pin interface. It drives the cell's A, B and CN pins through all 8 input vectors, samples X after a settle window, and compares X against a parameterised truth table.
- Sits beside the cell under test in characterisation and test harnesses. Reports pass/fail, the first failing vector and an error count.

Parameters:
- TRUTH, 8'hEF, expected X per vector index {CN,B,A}. Bit i is the expected X for index i. The default is the OR3-with-inverted-C function X = A | B | ~CN.
- SETTLE, 2, number of cycles the vector is held before sampling. Legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RESETB  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only in IDLE.
- obs_x  input  1  observed X from the cell under test. Must be synchronous to CLK or already settled.
- drv_a  output  1  A pin stimulus (vector bit 0).
- drv_b  output  1  B pin stimulus (vector bit 1).
- drv_cn  output  1  CN pin stimulus (vector bit 2).
- busy  output  1  run in progress.
- done  output  1  single-cycle pulse at the end of a run.
- pass  output  1  sticky result: 1 if there were no mismatches. Valid from done until the next start.
- fail_idx  output  3  index of the first mismatching vector. 0 if pass.
- err_count  output  4  number of mismatching vectors, 0..8.

Behaviour:
- Reset (RESETB low, asynchronous): state=IDLE, idx=0, settle counter=0.
  - All outputs are 0: drv_*, busy, done, pass, fail_idx, err_count.
  - Reset mid-run aborts the run immediately. No done pulse is produced.
- State IDLE:
  - drv_{cn,b,a} = 3'b000; busy=0.
  - When start=1 at a rising edge: go to DRIVE with idx=0, clear err_count, fail_idx and pass, and set busy=1.
- State DRIVE:
  - {drv_cn,drv_b,drv_a} = idx (registered outputs).
  - The settle counter counts from 0 to SETTLE-1. On the edge where it equals SETTLE-1, go to SAMPLE.
- State SAMPLE (1 cycle):
  - Drive outputs hold idx.
  - obs_x is compared against TRUTH[idx].
  - On mismatch: err_count increments. If this is the first mismatch, fail_idx=idx.
  - If idx==7, go to DONE. Otherwise idx increments, the settle counter clears, and the state returns to DRIVE.
- State DONE (1 cycle):
  - done=1 and busy=0.
  - pass=(err_count==0), counting the final SAMPLE result.
  - drv_* return to 0. Next state is IDLE.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done is asserted 8*(SETTLE+1)+1 cycles after the start edge. With the default SETTLE this is 25 cycles.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no restart.
  - start held high: the next run begins on the first IDLE cycle after DONE.
  - err_count reaching 8 is representable, so no saturation logic is required.
  - pass, fail_idx and err_count hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro SCS8HD_BIST_STOPFAIL_EN.
- Defined: on the first mismatch in SAMPLE, go straight to DONE.
  - fail_idx = that index, err_count = 1, pass=0.
  - Run length for a failure at index k is (k+1)*(SETTLE+1)+1 cycles to done.
- Undefined: all 8 vectors always run. err_count reports the total mismatches and fail_idx the first one.

Test Plan:
- Correct OR3-with-inverted-C model on obs_x, TRUTH=8'hEF, SETTLE=2, pulse start:
  - drv sequence steps 0..7, each vector held 3 cycles.
  - done is asserted 25 cycles after start; pass=1, err_count=0, fail_idx=0.
- Faulty model with obs_x stuck at 1 (vector 4 expects 0):
  - pass=0, fail_idx=4, err_count=1, done at cycle 25.
- Faulty model with obs_x stuck at 0:
  - pass=0, fail_idx=0, err_count=7.
- RESETB pulsed low during vector 3 of a run:
  - All outputs go to 0 immediately and no done pulse appears.
  - A fresh start afterwards completes normally with pass=1.
- Repeated start pulses while busy, including one during the DONE cycle:
  - Exactly one done pulse, at cycle 25.
  - A start in IDLE afterwards begins a new run with the counters cleared.
- SCS8HD_BIST_STOPFAIL_EN defined, obs_x stuck at 1, SETTLE=2:
  - done is asserted 16 cycles after start; fail_idx=4, err_count=1, pass=0.
